// File: rtl/calc_pkg.sv
// calc_pkg: shared types for the calculator front end.
//
// Provides the button encodings used between the keypad scanner and the
// calculator core:
//   active_button_t  - enumerated key identity, B_NONE marks "no button"
//   buttons_t        - one-hot press vector, bit k <-> enumerator k
//   Keymap           - key matrix index (row*NumCols+col) -> active_button_t
//   active2buttons() - active_button_t -> one-hot buttons_t
//   keypad_state_e   - keypad scanner FSM states (KeypadStateW bits)
package calc_pkg;

    typedef enum logic [4:0] {
        B_CLEAR,
        B_MEM_RECALL,
        B_MEM_CLEAR,
        B_MEM_SUB,
        B_MEM_ADD,
        B_OP_PERCENT,
        B_OP_SQRT,
        B_OP_DIV,
        B_OP_MUL,
        B_OP_SUB,
        B_OP_ADD,
        B_OP_EQ,
        B_DOT,
        B_NUM_1,
        B_NUM_2,
        B_NUM_3,
        B_NUM_4,
        B_NUM_5,
        B_NUM_6,
        B_NUM_7,
        B_NUM_8,
        B_NUM_9,
        B_NUM_0,
        B_NONE
    } active_button_t;

    localparam int NumButtons = 23;

    // Declared MSB first so that bit k of the packed vector is enumerator k.
    typedef struct packed {
        logic num_0;
        logic num_9;
        logic num_8;
        logic num_7;
        logic num_6;
        logic num_5;
        logic num_4;
        logic num_3;
        logic num_2;
        logic num_1;
        logic dot;
        logic op_eq;
        logic op_add;
        logic op_sub;
        logic op_mul;
        logic op_div;
        logic op_sqrt;
        logic op_percent;
        logic mem_add;
        logic mem_sub;
        logic mem_clear;
        logic mem_recall;
        logic clear;
    } buttons_t;

    // Key matrix index -> button. Positions past the last real button are
    // physically present on a 5x5 matrix but carry no function.
    localparam int KeymapSize = 32;
    localparam int KeymapIdxW = $clog2(KeymapSize);

    localparam active_button_t Keymap [KeymapSize] = '{
        0:  B_CLEAR,
        1:  B_MEM_RECALL,
        2:  B_MEM_CLEAR,
        3:  B_MEM_SUB,
        4:  B_MEM_ADD,
        5:  B_OP_PERCENT,
        6:  B_OP_SQRT,
        7:  B_OP_DIV,
        8:  B_OP_MUL,
        9:  B_OP_SUB,
        10: B_OP_ADD,
        11: B_OP_EQ,
        12: B_DOT,
        13: B_NUM_1,
        14: B_NUM_2,
        15: B_NUM_3,
        16: B_NUM_4,
        17: B_NUM_5,
        18: B_NUM_6,
        19: B_NUM_7,
        20: B_NUM_8,
        21: B_NUM_9,
        22: B_NUM_0,
        default: B_NONE
    };

    // B_NONE (and any code past the last button) produces an all-zero vector.
    function automatic buttons_t active2buttons(input active_button_t button);
        logic [NumButtons-1:0] vec;
        vec = '0;
        for (int i = 0; i < NumButtons; i++) begin
            vec[i] = (int'(button) == i);
        end
        return buttons_t'(vec);
    endfunction

    localparam int KeypadStateW = 2;

    typedef enum logic [KeypadStateW-1:0] {
        KS_SCAN,
        KS_DEBOUNCE,
        KS_EMIT,
        KS_WAIT_RELEASE
    } keypad_state_e;

endpackage

// File: rtl/keypad_debouncer.sv
// keypad_debouncer: counts consecutive matching samples.
//
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   sample - one-cycle strobe marking a valid row sample
//   match  - the sample agrees with the level being debounced
//   clear  - synchronous restart of the count
//   done   - combinational: this sample is the DebounceScans-th match in a row
//
// A mismatching sample restarts the run. The counter wraps to zero on the
// completing sample so the next phase always starts from a clean count.
module keypad_debouncer #(
    parameter int DebounceScans = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample,
    input  logic match,
    input  logic clear,
    output logic done
);

    localparam int CntW = $clog2(DebounceScans + 1);
    localparam logic [CntW-1:0] LastCount = CntW'(DebounceScans - 1);

    logic [CntW-1:0] count;

    assign done = sample && match && (count == LastCount);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || (sample && (!match || done))) begin
            count <= '0;
        end else if (sample) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: key matrix scanner feeding the calculator core.
//
// Drives one active-low column at a time, samples the active-low rows at the
// end of each column dwell, debounces a single key and emits a one-cycle
// one-hot buttons_t pulse per accepted press.
//
// Ports:
//   clk_i     - system clock
//   rst_ni    - asynchronous active-low reset
//   col_o     - column drive, active-low, exactly one bit low
//   row_i     - row sense, active-low, asynchronous to clk_i
//   buttons_o - one-hot press pulse, zero when idle
//   pressed_o - high while a debounced key is held
//
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-emit a held key after
// RepeatDelayScans samples and then every RepeatRateScans samples.
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int NumRows       = 5,
    parameter int NumCols       = 5,
    parameter int ScanDivider   = 1000,
    parameter int DebounceScans = 4
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    parameter int RepeatDelayScans = 500,
    parameter int RepeatRateScans  = 100
`endif
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    output logic [NumCols-1:0] col_o,
    input  logic [NumRows-1:0] row_i,
    output buttons_t           buttons_o,
    output logic               pressed_o
);

    localparam int DwellW = $clog2(ScanDivider);
    localparam int ColW   = $clog2(NumCols);
    localparam int RowW   = $clog2(NumRows);

    keypad_state_e state_q, state_d;

    logic [DwellW-1:0]  dwell;
    logic               sample;
    logic [NumRows-1:0] row_meta, row_sync;
    logic [NumRows-1:0] low;
    logic               any_low;
    logic [RowW-1:0]    first_row;
    logic [ColW-1:0]    col_idx;
    logic [RowW-1:0]    key_row;
    logic [ColW-1:0]    key_col;
    logic               key_low;
    logic               deb_match, deb_clear, deb_done;
    logic               advance, latch, emit;
    logic               repeat_pulse;
    int                 key_index;
    active_button_t     button;

    // Free-running dwell counter; the last cycle of each dwell is the sample.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dwell <= '0;
        end else if (sample) begin
            dwell <= '0;
        end else begin
            dwell <= dwell + 1'b1;
        end
    end

    assign sample = (dwell == DwellW'(ScanDivider - 1));

    // Two-flop synchronizer; idle rows read high, so reset to all ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row_i;
            row_sync <= row_meta;
        end
    end

    assign low     = ~row_sync;
    assign any_low = |low;
    assign key_low = low[key_row];

    // Lowest-index low row wins when several rows in one column are down.
    always_comb begin
        first_row = '0;
        for (int r = NumRows - 1; r >= 0; r--) begin
            if (low[r]) begin
                first_row = RowW'(r);
            end
        end
    end

    // Column pointer only moves in SCAN, or when leaving a key to resume.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_idx <= '0;
        end else if (advance) begin
            col_idx <= (col_idx == ColW'(NumCols - 1)) ? '0 : col_idx + 1'b1;
        end
    end

    always_comb begin
        col_o          = '1;
        col_o[col_idx] = 1'b0;
    end

    // Key latch: remembers which key the FSM is tracking.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_row <= '0;
            key_col <= '0;
        end else if (latch) begin
            key_row <= first_row;
            key_col <= col_idx;
        end
    end

    // What counts as a "matching" sample depends on the phase: any low row
    // while scanning, the tracked row low while debouncing a press, and the
    // tracked row high while waiting for release.
    always_comb begin
        deb_match = 1'b0;
        case (state_q)
            KS_SCAN:         deb_match = any_low;
            KS_DEBOUNCE:     deb_match = key_low;
            KS_WAIT_RELEASE: deb_match = !key_low;
            default:         deb_match = 1'b0;
        endcase
    end

    assign deb_clear = (state_q == KS_EMIT);

    keypad_debouncer #(
        .DebounceScans(DebounceScans)
    ) u_debouncer (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .sample(sample),
        .match (deb_match),
        .clear (deb_clear),
        .done  (deb_done)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= KS_SCAN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and FSM-derived controls.
    always_comb begin
        state_d   = state_q;
        advance   = 1'b0;
        latch     = 1'b0;
        emit      = 1'b0;
        pressed_o = 1'b0;
        case (state_q)
            KS_SCAN: begin
                if (sample) begin
                    if (any_low) begin
                        latch   = 1'b1;
                        state_d = deb_done ? KS_EMIT : KS_DEBOUNCE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            KS_DEBOUNCE: begin
                if (sample) begin
                    if (!key_low) begin
                        advance = 1'b1;
                        state_d = KS_SCAN;
                    end else if (deb_done) begin
                        state_d = KS_EMIT;
                    end
                end
            end
            KS_EMIT: begin
                emit    = 1'b1;
                state_d = KS_WAIT_RELEASE;
            end
            KS_WAIT_RELEASE: begin
                pressed_o = 1'b1;
                if (deb_done) begin
                    advance = 1'b1;
                    state_d = KS_SCAN;
                end
            end
            default: state_d = KS_SCAN;
        endcase
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RepMax = (RepeatDelayScans > RepeatRateScans) ? RepeatDelayScans : RepeatRateScans;
    localparam int RepW   = $clog2(RepMax + 1);

    logic [RepW-1:0] rep_cnt;
    logic            rep_first;
    logic            rep_fire;
    logic [RepW-1:0] rep_target;

    assign rep_target = rep_first ? RepW'(RepeatDelayScans) : RepW'(RepeatRateScans);

    // Counts low samples while held; the first repeat uses the long delay,
    // later ones the rate. Any high sample starts the timing over.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
            rep_fire  <= 1'b0;
        end else begin
            rep_fire <= 1'b0;
            if (state_q != KS_WAIT_RELEASE) begin
                rep_cnt   <= '0;
                rep_first <= 1'b1;
            end else if (sample) begin
                if (!key_low) begin
                    rep_cnt   <= '0;
                    rep_first <= 1'b1;
                end else if ((rep_cnt + RepW'(1)) == rep_target) begin
                    rep_cnt   <= '0;
                    rep_first <= 1'b0;
                    rep_fire  <= 1'b1;
                end else begin
                    rep_cnt <= rep_cnt + RepW'(1);
                end
            end
        end
    end

    assign repeat_pulse = rep_fire;
`else
    assign repeat_pulse = 1'b0;
`endif

    // Button lookup for the tracked key; out-of-map indices give B_NONE.
    always_comb begin
        key_index = int'(key_row) * NumCols + int'(key_col);
        button    = B_NONE;
        if (key_index < KeymapSize) begin
            button = Keymap[key_index[KeymapIdxW-1:0]];
        end
    end

    always_comb begin
        buttons_o = '0;
        if (emit || repeat_pulse) begin
            buttons_o = active2buttons(button);
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: self-checking bench for keypad_scanner.
//
// A virtual key matrix drives row_i from col_o. A sample-level reference
// model predicts column, pressed and pulse outputs every cycle; directed
// scenarios add explicit pulse-count and button-identity checks.
module tb_keypad_scanner;
    import calc_pkg::*;

    localparam int NumRows       = 5;
    localparam int NumCols       = 5;
    localparam int ScanDivider   = 4;
    localparam int DebounceScans = 3;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RepeatDelayScans = 5;
    localparam int RepeatRateScans  = 2;
`endif
    localparam int PhScan     = 0;
    localparam int PhDebounce = 1;
    localparam int PhHeld     = 2;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic [NumCols-1:0] col_o;
    logic [NumRows-1:0] row_i;
    buttons_t           buttons_o;
    logic               pressed_o;

    bit keys [NumRows][NumCols];

    int n_asserts = 0;
    int n_fail    = 0;
    int edges;
    int m_phase, m_col, m_row, m_kcol, m_cnt, m_rel, m_since;
    bit m_repeated, emit_now, fire_now;
    logic [22:0] m_button;
    int obs_pulses;
    logic [22:0] last_button;
    buttons_t lb;

    always #5 clk_i = ~clk_i;

    // Physical matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        for (int r = 0; r < NumRows; r++) begin
            row_i[r] = 1'b1;
            for (int c = 0; c < NumCols; c++) begin
                if (keys[r][c] && !col_o[c]) row_i[r] = 1'b0;
            end
        end
    end

    keypad_scanner #(
        .NumRows      (NumRows),
        .NumCols      (NumCols),
        .ScanDivider  (ScanDivider),
        .DebounceScans(DebounceScans)
`ifdef KEYPAD_AUTOREPEAT_EN
        ,
        .RepeatDelayScans(RepeatDelayScans),
        .RepeatRateScans (RepeatRateScans)
`endif
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .col_o    (col_o),
        .row_i    (row_i),
        .buttons_o(buttons_o),
        .pressed_o(pressed_o)
    );

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_phase    = PhScan;
        m_col      = 0;
        m_cnt      = 0;
        m_rel      = 0;
        m_since    = 0;
        m_repeated = 0;
        emit_now   = 0;
        fire_now   = 0;
        edges      = 0;
    endtask

    // Button of key (row, col): bit row*NumCols+col, nothing past 22.
    task automatic accept();
        int idx;
        idx      = m_row * NumCols + m_kcol;
        m_button = '0;
        if (idx < 23) m_button[idx] = 1'b1;
        m_phase    = PhHeld;
        m_rel      = 0;
        m_since    = 0;
        m_repeated = 0;
        emit_now   = 1;
    endtask

    // Applies the scanning rules to one sample of the current key matrix.
    task automatic model_sample();
        int low_row;
        if (m_phase == PhScan) begin
            low_row = -1;
            for (int r = NumRows - 1; r >= 0; r--) if (keys[r][m_col]) low_row = r;
            if (low_row >= 0) begin
                m_row  = low_row;
                m_kcol = m_col;
                m_cnt  = 1;
                if (m_cnt == DebounceScans) accept();
                else m_phase = PhDebounce;
            end else begin
                m_col = (m_col + 1) % NumCols;
            end
        end else if (m_phase == PhDebounce) begin
            if (keys[m_row][m_kcol]) begin
                m_cnt++;
                if (m_cnt == DebounceScans) accept();
            end else begin
                m_phase = PhScan;
                m_col   = (m_col + 1) % NumCols;
            end
        end else begin
            if (!keys[m_row][m_kcol]) begin
                m_rel++;
                m_since    = 0;
                m_repeated = 0;
                if (m_rel == DebounceScans) begin
                    m_phase = PhScan;
                    m_col   = (m_col + 1) % NumCols;
                end
            end else begin
                m_rel = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
                m_since++;
                if (m_since == (m_repeated ? RepeatRateScans : RepeatDelayScans)) begin
                    fire_now   = 1;
                    m_since    = 0;
                    m_repeated = 1;
                end
`endif
            end
        end
    endtask

    task automatic tick();
        logic [NumCols-1:0] exp_col;
        logic [22:0]        exp_btn;
        logic [22:0]        got_btn;
        @(posedge clk_i);
        edges++;
        emit_now = 0;
        fire_now = 0;
        if (edges % ScanDivider == 0) model_sample();
        #1;
        exp_col        = '1;
        exp_col[m_col] = 1'b0;
        exp_btn        = (emit_now || fire_now) ? m_button : '0;
        got_btn        = buttons_o;
        check_output("col_o", 32'(col_o), 32'(exp_col));
        check_output("buttons_o", 32'(got_btn), 32'(exp_btn));
        check_output("pressed_o", 32'(pressed_o), 32'(m_phase == PhHeld && !emit_now));
        if (got_btn != '0) begin
            obs_pulses++;
            last_button = got_btn;
        end
    endtask

    task automatic run_scans(input int n);
        repeat (n * ScanDivider) tick();
    endtask

    task automatic align();
        while (edges % ScanDivider != 0) tick();
    endtask

    task automatic clear_keys();
        foreach (keys[r, c]) keys[r][c] = 0;
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        clear_keys();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
        #1;
        check_output("reset_col", 32'(col_o), 32'h1E);
        check_output("reset_buttons", 32'(buttons_o), 32'h0);
        check_output("reset_pressed", 32'(pressed_o), 32'h0);
    endtask

    task automatic wait_pressed(input string tag);
        int budget;
        budget = 400;
        while (pressed_o !== 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        check_output(tag, 32'(pressed_o), 32'h1);
    endtask

    task automatic wait_debounce();
        int budget;
        budget = 400;
        while (m_phase != PhDebounce && budget > 0) begin
            tick();
            budget--;
        end
    endtask

    initial begin
        obs_pulses  = 0;
        last_button = '0;
        clear_keys();

        // Reset values, then the first column step.
        apply_reset();
        run_scans(1);
        check_output("col_after_dwell", 32'(col_o), 32'h1D);

        // Clean press of row 4, col 2 -> num_0.
        align();
        obs_pulses = 0;
        keys[4][2] = 1;
        wait_pressed("press_num0_timeout");
        run_scans(2);
        lb = last_button;
        check_output("num0_pulse_count", 32'(obs_pulses), 32'd1);
        check_output("num0_button", 32'(lb.num_0), 32'd1);
        check_output("num0_held", 32'(pressed_o), 32'd1);
        align();
        keys[4][2] = 0;
        run_scans(DebounceScans - 1);
        check_output("release_not_yet", 32'(pressed_o), 32'd1);
        run_scans(1);
        check_output("release_done", 32'(pressed_o), 32'd0);
        run_scans(6);

        // Bounce on row 2, col 3 -> a single num_1 only after steady low.
        align();
        obs_pulses = 0;
        keys[2][3] = 1;
        wait_debounce();
        keys[2][3] = 0;
        run_scans(1);
        check_output("bounce_no_pulse", 32'(obs_pulses), 32'd0);
        keys[2][3] = 1;
        wait_pressed("bounce_timeout");
        run_scans(2);
        lb = last_button;
        check_output("bounce_pulse_count", 32'(obs_pulses), 32'd1);
        check_output("bounce_num1", 32'(lb.num_1), 32'd1);
        align();
        clear_keys();
        run_scans(6);

        // Rows 1 and 3 in column 0 -> lowest row wins, op_percent.
        align();
        obs_pulses = 0;
        keys[1][0] = 1;
        keys[3][0] = 1;
        wait_pressed("two_rows_timeout");
        run_scans(2);
        lb = last_button;
        check_output("two_rows_count", 32'(obs_pulses), 32'd1);
        check_output("two_rows_percent", 32'(lb.op_percent), 32'd1);
        align();
        clear_keys();
        run_scans(6);

        // Unmapped key row 4, col 3 -> no pulse but held.
        align();
        obs_pulses = 0;
        keys[4][3] = 1;
        wait_pressed("unmapped_timeout");
        run_scans(2);
        check_output("unmapped_no_pulse", 32'(obs_pulses), 32'd0);
        check_output("unmapped_held", 32'(pressed_o), 32'd1);
        align();
        clear_keys();
        run_scans(5);
        check_output("unmapped_released", 32'(pressed_o), 32'd0);

        // Reset during debounce: outputs return to reset values at once.
        align();
        obs_pulses = 0;
        keys[0][1] = 1;
        wait_debounce();
        tick();
        rst_ni = 1'b0;
        #1;
        check_output("async_rst_col", 32'(col_o), 32'h1E);
        check_output("async_rst_pressed", 32'(pressed_o), 32'd0);
        check_output("async_rst_buttons", 32'(buttons_o), 32'd0);
        apply_reset();
        run_scans(8);
        check_output("async_rst_no_pulse", 32'(obs_pulses), 32'd0);

`ifdef KEYPAD_AUTOREPEAT_EN
        // Held B_CLEAR: pulses at accept, +5, +7, +9, +11 samples.
        begin
            int budget;
            align();
            obs_pulses = 0;
            keys[0][0] = 1;
            budget = 400;
            while (obs_pulses == 0 && budget > 0) begin
                tick();
                budget--;
            end
            run_scans(12);
            align();
            keys[0][0] = 0;
            run_scans(5);
            lb = last_button;
            check_output("repeat_count", 32'(obs_pulses), 32'd5);
            check_output("repeat_clear", 32'(lb.clear), 32'd1);
        end
`endif

        // Randomized presses, bounces and second keys in other columns.
        repeat (12) begin
            int r, c, bounce;
            r = $urandom_range(NumRows - 1);
            c = $urandom_range(NumCols - 1);
            bounce = $urandom_range(2);
            align();
            for (int b = 0; b < bounce; b++) begin
                keys[r][c] = 1;
                run_scans($urandom_range(1, 2));
                keys[r][c] = 0;
                run_scans(1);
            end
            keys[r][c] = 1;
            if ($urandom_range(1) == 1) keys[$urandom_range(NumRows - 1)][(c + 1) % NumCols] = 1;
            run_scans($urandom_range(14, 30));
            clear_keys();
            run_scans(NumCols + DebounceScans + 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Front-end stage upstream of the calculator core. Drives a physical key matrix column by column and samples the rows. Debounces one key at a time and emits a single-cycle one-hot calc_pkg::buttons_t pulse per accepted press. Only one key is ever reported per press/release cycle.

Parameters:
NumRows, 5, matrix rows (row_i width)
NumCols, 5, matrix columns (col_o width)
ScanDivider, 1000, clock cycles each column is held (dwell); minimum 4
DebounceScans, 4, consecutive matching samples needed to accept a press or a release; minimum 1

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
col_o  output  NumCols  column drive, active-low, exactly one bit low at all times
row_i  input  NumRows  row sense, active-low (pulled up externally), asynchronous
buttons_o  output  calc_pkg::buttons_t  one-hot press pulse, all-zero when idle
pressed_o  output  1  high while a debounced key is held (DEBOUNCE excluded)

Behaviour:
- Interface: one clock, clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: col_o = ~1 (column 0 driven); buttons_o = '0; pressed_o = 0; FSM = SCAN; all counters = 0.
- row_i passes through a 2-flop synchronizer. "Sample" means the synchronized rows captured on the last cycle of a dwell (dwell counter == ScanDivider-1).
- Key index = row*NumCols + col.
- Index k maps to the k-th enumerator of calc_pkg::active_button_t, in this order: B_CLEAR, B_MEM_RECALL, B_MEM_CLEAR, B_MEM_SUB, B_MEM_ADD, B_OP_PERCENT, B_OP_SQRT, B_OP_DIV, B_OP_MUL, B_OP_SUB, B_OP_ADD, B_OP_EQ, B_DOT, B_NUM_1 through B_NUM_9, B_NUM_0 (indices 0 to 22).
- Indices 23 and above are unmapped.
- FSM states and transitions:
  - SCAN: the column advances after each sample, wrapping NumCols-1 -> 0.
    - Sample with any row low: latch the lowest-index low row and the current column, set count=1, go to DEBOUNCE. The column stops advancing.
    - If DebounceScans==1, go directly to EMIT.
  - DEBOUNCE: the column is held.
    - Sample with the latched row low: count++. When count reaches DebounceScans, go to EMIT.
    - Sample with the latched row high: go to SCAN. The column resumes advancing from the next column.
  - EMIT: one cycle.
    - buttons_o = one-hot of the mapped button; an unmapped index gives all-zero.
    - Go to WAIT_RELEASE.
  - WAIT_RELEASE: the column is held; pressed_o = 1.
    - Requires DebounceScans consecutive samples with the latched row high before returning to SCAN, with count reset.
    - Any low sample resets the release count.
- Press latency: the buttons_o pulse appears 1 cycle after the sample that completes the debounce.
- Simultaneous keys:
  - Within one column, the lowest row wins.
  - A key in another column pressed while one is held is ignored until release and re-scan.
- Reset asserted mid-operation: all state returns to reset values immediately; no pulse is emitted.
- Width rules:
  - Dwell counter width = $clog2(ScanDivider).
  - Debounce counter width = $clog2(DebounceScans+1).
  - Column index width = $clog2(NumCols).

Optional Feature:
KEYPAD_AUTOREPEAT_EN:
- When defined, adds parameters RepeatDelayScans (default 500) and RepeatRateScans (default 100).
- While in WAIT_RELEASE with the key still low, the same button is re-emitted as a 1-cycle pulse:
  - first after RepeatDelayScans samples,
  - then every RepeatRateScans samples.
- Any high sample restarts the repeat timing.
- When undefined, there is exactly one pulse per press and the repeat logic and parameters are absent.

Decomposition:
- calc_pkg: add a synthesizable keymap constant (array of active_button_t indexed by key index) and function active2buttons(active_button_t) -> buttons_t, so the mapping is not DV-only.
- Add KeypadStateW and the FSM state enum to calc_pkg.
- One sub-module is natural: keypad_debouncer, the counter plus match/mismatch logic, instantiated once. The scanner owns the column counter, the FSM and the mapping.

Test Plan:
All scenarios use ScanDivider=4 and DebounceScans=3.
- Reset check: hold rst_ni low, then release -> col_o=5'b11110, buttons_o=0, pressed_o=0; col_o rotates to 5'b11101 after 4 cycles.
- Clean press of row 4, col 2 (row_i[4] low whenever col_o[2] low) -> exactly one buttons_o.num_0 pulse, pressed_o=1.
  - Release -> pressed_o=0 after 3 high samples; scanning resumes.
- Bounce: row 2, col 3 low for 1 sample, high for 1, then steady low -> no pulse until 3 consecutive low samples, then one num_1 pulse.
- Two rows low in column 0 (rows 1 and 3) -> the single pulse is op_percent (index 5).
- Unmapped key at row 4, col 3 (index 23) -> no pulse, but pressed_o=1 until release.
- With KEYPAD_AUTOREPEAT_EN, RepeatDelayScans=5, RepeatRateScans=2: hold B_CLEAR (row 0, col 0) for 12 samples after accept -> clear pulses at the accept and at +5, +7, +9 and +11 samples.
